// File: rtl/fb_pixel_packer_if.sv
// Pixel-stream and framebuffer-write bus for fb_pixel_packer.
//   master : painter side; drives pix_*/flush, observes ram_*/idle/dropped
//   slave  : packer side; consumes pixels, drives RAM write port and status
interface fb_pixel_packer_if #(
    parameter int COOR_WIDTH   = 11,
    parameter int PIX_PER_WORD = 16,
    parameter int ADDR_WIDTH   = 15
);
    logic                      pix_valid;
    logic [COOR_WIDTH-1:0]     pix_x;
    logic [COOR_WIDTH-1:0]     pix_y;
    logic [1:0]                pix_palette;
    logic                      flush;
    logic                      ram_we;
    logic [ADDR_WIDTH-1:0]     ram_addr;
    logic [2*PIX_PER_WORD-1:0] ram_data;
    logic [PIX_PER_WORD-1:0]   ram_mask;
    logic                      idle;
    logic                      dropped;

    modport master (
        output pix_valid, pix_x, pix_y, pix_palette, flush,
        input  ram_we, ram_addr, ram_data, ram_mask, idle, dropped
    );

    modport slave (
        input  pix_valid, pix_x, pix_y, pix_palette, flush,
        output ram_we, ram_addr, ram_data, ram_mask, idle, dropped
    );
endinterface

// File: rtl/fb_pixel_packer.sv
// Packs a one-pixel-per-cycle (x, y, 2-bit palette) stream into masked
// framebuffer word writes. Adjacent pixels of the same word are merged in an
// accumulator; a word is written when it fills, when the stream moves to a
// different word, or on flush.
//   clk_33m : clock
//   rst     : synchronous, active-high reset
//   bus     : slave side of fb_pixel_packer_if (pixel in, RAM write out,
//             idle / sticky dropped status)
module fb_pixel_packer #(
    parameter int COOR_WIDTH   = 11,
    parameter int WIDTH        = 1280,
    parameter int HEIGHT       = 300,
    parameter int PIX_PER_WORD = 16,
    parameter int ADDR_WIDTH   = 15
) (
    input logic              clk_33m,
    input logic              rst,
    fb_pixel_packer_if.slave bus
);
    localparam int LANE_W = $clog2(PIX_PER_WORD);
    localparam int DATA_W = 2 * PIX_PER_WORD;
    localparam logic [COOR_WIDTH-1:0] X_LIM = COOR_WIDTH'(WIDTH);
    localparam logic [COOR_WIDTH-1:0] Y_LIM = COOR_WIDTH'(HEIGHT);
    localparam logic [ADDR_WIDTH-1:0] WORDS_PER_ROW = ADDR_WIDTH'(WIDTH / PIX_PER_WORD);
    localparam logic [COOR_WIDTH-1:0] PPW_C = COOR_WIDTH'(PIX_PER_WORD);

    typedef enum logic {EMPTY, ACCUM} state_t;

    state_t                  r_state, w_nxt_state;
    logic [ADDR_WIDTH-1:0]   r_acc_addr, w_nxt_acc_addr;
    logic [DATA_W-1:0]       r_acc_data, w_nxt_acc_data;
    logic [PIX_PER_WORD-1:0] r_acc_mask, w_nxt_acc_mask;

    // One-entry queue holding the new word that arrived together with flush
    logic                    r_q_valid, w_nxt_q_valid;
    logic [ADDR_WIDTH-1:0]   r_q_addr, w_nxt_q_addr;
    logic [DATA_W-1:0]       r_q_data, w_nxt_q_data;
    logic [PIX_PER_WORD-1:0] r_q_mask, w_nxt_q_mask;

    logic                    r_ram_we;
    logic [ADDR_WIDTH-1:0]   r_ram_addr;
    logic [DATA_W-1:0]       r_ram_data;
    logic [PIX_PER_WORD-1:0] r_ram_mask;
    logic                    r_dropped;

    logic                    w_in_range, w_accept, w_same;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [LANE_W-1:0]       w_lane;
    logic [PIX_PER_WORD-1:0] w_onehot, w_merged_mask;
    logic [DATA_W-1:0]       w_pix_data, w_lane_bits, w_merged_data;

    logic                    w_we;
    logic [ADDR_WIDTH-1:0]   w_we_addr;
    logic [DATA_W-1:0]       w_we_data;
    logic [PIX_PER_WORD-1:0] w_we_mask;

    assign w_in_range = (bus.pix_x < X_LIM) && (bus.pix_y < Y_LIM);
    assign w_accept   = bus.pix_valid && w_in_range;
    assign w_addr     = ADDR_WIDTH'(bus.pix_y) * WORDS_PER_ROW + ADDR_WIDTH'(bus.pix_x / PPW_C);
    assign w_lane     = LANE_W'(bus.pix_x % PPW_C);
    assign w_onehot   = PIX_PER_WORD'(1) << w_lane;
    assign w_pix_data = DATA_W'(bus.pix_palette) << (2 * w_lane);
    assign w_lane_bits = DATA_W'(2'b11) << (2 * w_lane);
    assign w_same     = (w_addr == r_acc_addr);
    // Clear the lane before OR-ing so a repeated lane takes the newest value
    assign w_merged_data = (r_acc_data & ~w_lane_bits) | w_pix_data;
    assign w_merged_mask = r_acc_mask | w_onehot;

    always_ff @(posedge clk_33m) begin
        if (rst) r_state <= EMPTY;
        else     r_state <= w_nxt_state;
    end

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_acc_addr = r_acc_addr;
        w_nxt_acc_data = r_acc_data;
        w_nxt_acc_mask = r_acc_mask;
        w_nxt_q_valid  = 1'b0;
        w_nxt_q_addr   = r_q_addr;
        w_nxt_q_data   = r_q_data;
        w_nxt_q_mask   = r_q_mask;
        w_we           = 1'b0;
        w_we_addr      = r_acc_addr;
        w_we_data      = r_acc_data;
        w_we_mask      = r_acc_mask;
        case (r_state)
            EMPTY: begin
                // flush alone has no effect here; a pixel just starts a word
                if (w_accept) begin
                    w_nxt_acc_addr = w_addr;
                    w_nxt_acc_data = w_pix_data;
                    w_nxt_acc_mask = w_onehot;
                    w_nxt_state    = ACCUM;
                end
            end
            ACCUM: begin
                if (w_accept && w_same) begin
                    if (bus.flush || (&w_merged_mask)) begin
                        w_we           = 1'b1;
                        w_we_data      = w_merged_data;
                        w_we_mask      = w_merged_mask;
                        w_nxt_acc_data = '0;
                        w_nxt_acc_mask = '0;
                        w_nxt_state    = EMPTY;
                    end else begin
                        w_nxt_acc_data = w_merged_data;
                        w_nxt_acc_mask = w_merged_mask;
                    end
                end else if (w_accept) begin
                    w_we = 1'b1;
                    if (bus.flush) begin
                        // New word must also go out; park it for next cycle
                        w_nxt_q_valid  = 1'b1;
                        w_nxt_q_addr   = w_addr;
                        w_nxt_q_data   = w_pix_data;
                        w_nxt_q_mask   = w_onehot;
                        w_nxt_acc_data = '0;
                        w_nxt_acc_mask = '0;
                        w_nxt_state    = EMPTY;
                    end else begin
                        w_nxt_acc_addr = w_addr;
                        w_nxt_acc_data = w_pix_data;
                        w_nxt_acc_mask = w_onehot;
                    end
                end else if (bus.flush) begin
                    w_we           = 1'b1;
                    w_nxt_acc_data = '0;
                    w_nxt_acc_mask = '0;
                    w_nxt_state    = EMPTY;
                end
            end
            default: w_nxt_state = EMPTY;
        endcase
        // The queue is only loaded on the way to EMPTY, so the cycle it
        // drains the accumulator can only load, never emit.
        if (r_q_valid) begin
            w_we      = 1'b1;
            w_we_addr = r_q_addr;
            w_we_data = r_q_data;
            w_we_mask = r_q_mask;
        end
    end

    always_ff @(posedge clk_33m) begin
        if (rst) begin
            r_acc_addr <= '0;
            r_acc_data <= '0;
            r_acc_mask <= '0;
            r_q_valid  <= 1'b0;
            r_q_addr   <= '0;
            r_q_data   <= '0;
            r_q_mask   <= '0;
            r_ram_we   <= 1'b0;
            r_ram_addr <= '0;
            r_ram_data <= '0;
            r_ram_mask <= '0;
            r_dropped  <= 1'b0;
        end else begin
            r_acc_addr <= w_nxt_acc_addr;
            r_acc_data <= w_nxt_acc_data;
            r_acc_mask <= w_nxt_acc_mask;
            r_q_valid  <= w_nxt_q_valid;
            r_q_addr   <= w_nxt_q_addr;
            r_q_data   <= w_nxt_q_data;
            r_q_mask   <= w_nxt_q_mask;
            r_ram_we   <= w_we;
            if (w_we) begin
                r_ram_addr <= w_we_addr;
                r_ram_data <= w_we_data;
                r_ram_mask <= w_we_mask;
            end
            if (bus.pix_valid && !w_in_range) r_dropped <= 1'b1;
        end
    end

    assign bus.ram_we   = r_ram_we;
    assign bus.ram_addr = r_ram_addr;
    assign bus.ram_data = r_ram_data;
    assign bus.ram_mask = r_ram_mask;
    assign bus.dropped  = r_dropped;
    assign bus.idle     = (r_state == EMPTY) && !r_q_valid && !r_ram_we;
endmodule

// File: tb/tb_fb_pixel_packer.sv
module tb_fb_pixel_packer;
    localparam int CW = 11, W = 1280, H = 300, PPW = 16, AW = 15;

    typedef struct {
        int unsigned addr;
        int unsigned mask;
        int unsigned data;
    } wr_t;

    logic clk_33m = 1'b0;
    logic rst     = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_writes = 0;
    wr_t  exp_q[$];

    always #15 clk_33m = ~clk_33m;

    fb_pixel_packer_if #(.COOR_WIDTH(CW), .PIX_PER_WORD(PPW), .ADDR_WIDTH(AW)) bus ();

    fb_pixel_packer #(
        .COOR_WIDTH(CW), .WIDTH(W), .HEIGHT(H), .PIX_PER_WORD(PPW), .ADDR_WIDTH(AW)
    ) dut (
        .clk_33m (clk_33m),
        .rst     (rst),
        .bus     (bus.slave)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input int unsigned a, input int unsigned m, input int unsigned d);
        wr_t e;
        e.addr = a; e.mask = m; e.data = d;
        exp_q.push_back(e);
    endtask

    // Present one input beat for exactly one clock edge; returns #1 after it
    task automatic step(input logic v, input int x, input int y, input int pal, input logic fl);
        bus.pix_valid   = v;
        bus.pix_x       = CW'(x);
        bus.pix_y       = CW'(y);
        bus.pix_palette = 2'(pal);
        bus.flush       = fl;
        @(posedge clk_33m); #1;
        bus.pix_valid = 1'b0;
        bus.flush     = 1'b0;
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) step(1'b0, 0, 0, 0, 1'b0);
    endtask

    // Scoreboard monitor: compares every write the DUT issues
    always @(negedge clk_33m) begin
        if (!rst && bus.ram_we === 1'b1) begin
            wr_t e;
            n_writes++;
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_write: got addr %0d mask 0x%0h data 0x%0h, expected none",
                         bus.ram_addr, bus.ram_mask, bus.ram_data);
            end else begin
                e = exp_q.pop_front();
                check("wr_addr", longint'(bus.ram_addr), longint'(e.addr));
                check("wr_mask", longint'(bus.ram_mask), longint'(e.mask));
                check("wr_data", longint'(bus.ram_data), longint'(e.data));
            end
        end
    end

    task automatic drain_check(input string name);
        int n = 0;
        while (exp_q.size() != 0 && n < 20) begin
            idle_cycles(1);
            n++;
        end
        check(name, longint'(exp_q.size()), 0);
        if (exp_q.size() != 0) exp_q.delete();
    endtask

    initial begin
        int wr0;
        bus.pix_valid = 1'b0; bus.pix_x = '0; bus.pix_y = '0;
        bus.pix_palette = '0; bus.flush = 1'b0;
        repeat (2) @(posedge clk_33m);
        #1;
        check("rst_we",      longint'(bus.ram_we),   0);
        check("rst_addr",    longint'(bus.ram_addr), 0);
        check("rst_data",    longint'(bus.ram_data), 0);
        check("rst_mask",    longint'(bus.ram_mask), 0);
        check("rst_idle",    longint'(bus.idle),     1);
        check("rst_dropped", longint'(bus.dropped),  0);
        rst = 1'b0;
        idle_cycles(1);

        // Raster of palette 3: first rows and the last row of the frame
        wr0 = n_writes;
        for (int y = 0; y < H; y++) begin
            if (y >= 4 && y != H - 1) continue;
            for (int x = 0; x < W; x++) begin
                step(1'b1, x, y, 3, 1'b0);
                if (x % PPW == PPW - 1) push(y * (W / PPW) + x / PPW, 32'hFFFF, 32'hFFFF_FFFF);
            end
        end
        step(1'b0, 0, 0, 0, 1'b1);
        check("frame_flush_nowrite", longint'(bus.ram_we), 0);
        drain_check("frame_sb_empty");
        idle_cycles(2);
        check("frame_write_count", longint'(n_writes - wr0), 5 * (W / PPW));
        check("frame_idle", longint'(bus.idle), 1);

        // Partial word flush
        push(0, 32'h0007, 32'h0000_0039);
        step(1'b1, 0, 0, 1, 1'b0);
        step(1'b1, 1, 0, 2, 1'b0);
        step(1'b1, 2, 0, 3, 1'b0);
        check("partial_no_early_write", longint'(bus.ram_we), 0);
        step(1'b0, 0, 0, 0, 1'b1);
        check("partial_we_after_flush", longint'(bus.ram_we), 1);
        drain_check("partial_sb_empty");

        // Word change evicts the old word one cycle after the new pixel
        push(0, 32'hC000, 32'hF000_0000);
        push(1, 32'h0001, 32'h0000_0001);
        step(1'b1, 14, 0, 3, 1'b0);
        step(1'b1, 15, 0, 3, 1'b0);
        step(1'b1, 16, 0, 1, 1'b0);
        check("wchg_we_timing", longint'(bus.ram_we), 1);
        check("wchg_addr_timing", longint'(bus.ram_addr), 0);
        step(1'b0, 0, 0, 0, 1'b1);
        drain_check("wchg_sb_empty");

        // Flush together with a different-word pixel: two back-to-back writes
        push(80, 32'h0001, 32'h2);
        push(82, 32'h0001, 32'h1);
        step(1'b1, 0, 1, 2, 1'b0);
        step(1'b1, 32, 1, 1, 1'b1);
        check("fnew_first_we", longint'(bus.ram_we), 1);
        check("fnew_idle_busy", longint'(bus.idle), 0);
        idle_cycles(1);
        check("fnew_second_we", longint'(bus.ram_we), 1);
        check("fnew_second_addr", longint'(bus.ram_addr), 82);
        drain_check("fnew_sb_empty");
        idle_cycles(1);
        check("fnew_idle_after", longint'(bus.idle), 1);

        // Out-of-range pixels, then duplicate lane
        step(1'b1, 1280, 0, 3, 1'b0);
        check("oor_x_dropped", longint'(bus.dropped), 1);
        check("oor_x_idle", longint'(bus.idle), 1);
        step(1'b1, 0, 300, 3, 1'b0);
        check("oor_y_idle", longint'(bus.idle), 1);
        push(160, 32'h0020, 32'h0000_0800);
        step(1'b1, 5, 2, 1, 1'b0);
        step(1'b1, 5, 2, 2, 1'b0);
        step(1'b0, 0, 0, 0, 1'b1);
        drain_check("dup_sb_empty");
        check("dropped_sticky", longint'(bus.dropped), 1);

        // Reset in the middle of accumulation discards the word
        for (int i = 0; i < 8; i++) step(1'b1, 32 + i, 5, 2, 1'b0);
        rst = 1'b1;
        idle_cycles(1);
        rst = 1'b0;
        check("mrst_we",      longint'(bus.ram_we),   0);
        check("mrst_addr",    longint'(bus.ram_addr), 0);
        check("mrst_data",    longint'(bus.ram_data), 0);
        check("mrst_mask",    longint'(bus.ram_mask), 0);
        check("mrst_idle",    longint'(bus.idle),     1);
        check("mrst_dropped", longint'(bus.dropped),  0);
        wr0 = n_writes;
        step(1'b0, 0, 0, 0, 1'b1);
        idle_cycles(4);
        check("mrst_no_write", longint'(n_writes - wr0), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule

// File: doc/fb_pixel_packer.md
Name: fb_pixel_packer

Overview:
- Sits directly downstream of the background/sprite painters; consumes their per-pixel stream (x, y, 2-bit palette index) and packs it into framebuffer RAM words.
- Each RAM word holds PIX_PER_WORD horizontally adjacent pixels.
- Consecutive pixels in the same word are merged, and one masked word write is issued per word, so the painters' one-pixel-per-cycle stream never needs backpressure.

Parameters:
- COOR_WIDTH, 11: width of the x/y pixel coordinates.
- WIDTH, 1280: frame width in pixels; must be a multiple of PIX_PER_WORD.
- HEIGHT, 300: frame height in pixels.
- PIX_PER_WORD, 16: pixels per RAM word, 2 bits each.
- ADDR_WIDTH, 15: RAM word-address width; must satisfy 2^ADDR_WIDTH >= WIDTH*HEIGHT/PIX_PER_WORD.

Ports:
- clk_33m  in  1  clock
- rst  in  1  reset; synchronous, active-high
- pix_valid  in  1  pixel present this cycle
- pix_x  in  COOR_WIDTH  pixel column
- pix_y  in  COOR_WIDTH  pixel row
- pix_palette  in  2  palette index
- flush  in  1  force out any partially filled word
- ram_we  out  1  RAM write strobe, one cycle per word
- ram_addr  out  ADDR_WIDTH  word address
- ram_data  out  2*PIX_PER_WORD  packed pixels
- ram_mask  out  PIX_PER_WORD  per-pixel lane write enable
- idle  out  1  accumulator empty and no write in flight
- dropped  out  1  sticky: an out-of-range pixel was discarded

Behaviour:
- Clock and reset: clk_33m is the clock. rst is synchronous, active-high, and always takes priority, including mid-accumulation. A partially filled word is discarded on reset, not written.
- Reset values: state EMPTY, accumulator data/mask 0, ram_we 0, ram_addr 0, ram_data 0, ram_mask 0, dropped 0, idle 1.
- Address mapping (pixel accepted):
  - word address = pix_y*(WIDTH/PIX_PER_WORD) + pix_x/PIX_PER_WORD, computed at ADDR_WIDTH bits.
  - lane = pix_x mod PIX_PER_WORD.
  - Data bits [2*lane+1 : 2*lane] = pix_palette; lane 0 is the LSBs.
- Range check: pixel with pix_x >= WIDTH or pix_y >= HEIGHT is ignored, sets dropped (cleared only by rst), and does not disturb the accumulator.
- States:
  - EMPTY: no pending lanes. A valid in-range pixel loads acc_addr and sets that single lane, then goes to ACCUM.
  - ACCUM, same acc_addr: pixel is merged into its lane; a repeated lane takes the newest value (last write wins).
  - ACCUM, different address: the current accumulator is emitted, and the new pixel starts a fresh accumulator in the same cycle; stay in ACCUM.
  - ACCUM, mask becomes all ones after merge: emit, go to EMPTY.
  - flush=1 in ACCUM: merge any same-word pixel first, then emit, go to EMPTY.
  - flush=1 with a different-word pixel: emit the old word; the new pixel is also flushed as a second write on the following cycle.
  - flush in EMPTY: no effect.
- Emit register: outputs are registered. A word completed or evicted at cycle N appears with ram_we=1 at cycle N+1 for exactly one cycle, with ram_mask = accumulated lanes. ram_data lanes outside the mask are 0.
- Second-write queue: one-entry pending queue for the flush-plus-new-word case. At most one write per cycle. If a pixel arrives while the queue is occupied, it is accepted normally; only the queue drains.
- Steady state: throughput of one pixel per cycle with no stalls. A full contiguous row produces one write every PIX_PER_WORD cycles.
- idle: 1 iff state EMPTY, queue empty, and ram_we=0.

Test Plan:
- Full frame: feed 1280x300 raster of palette 3, one per cycle, then flush.
  - Exactly 24000 writes, addresses 0..23999 ascending, every mask 0xFFFF, data 0xFFFFFFFF.
  - Flush produces no extra write; idle=1 afterwards.
- Partial word flush: pixels (0,0)=1, (1,0)=2, (2,0)=3, then flush.
  - One write: addr 0, mask 0x0007, data 0x00000039.
- Word change: (14,0)=3, (15,0)=3, (16,0)=1.
  - Write addr 0, mask 0xC000, data 0xF0000000 one cycle after (16,0).
  - Then flush gives addr 1, mask 0x0001, data 0x00000001.
- Simultaneous flush + new word: accumulator holds (0,1)=2 (addr 80); present (32,1)=1 with flush=1.
  - Consecutive writes: addr 80 mask 0x0001 data 0x2, then addr 82 mask 0x0001 data 0x1.
- Out-of-range and duplicate lane:
  - (1280,0)=3 sets dropped=1, no write.
  - (5,2)=1 then (5,2)=2 then flush gives one write: addr 160, mask 0x0020, data 0x00000800.
- Reset mid-operation: accumulate 8 pixels, assert rst one cycle.
  - No write ever emitted for them; all outputs at reset values; idle=1, dropped=0.
